// File: rtl/adpll_frac_seq.sv
// Fractional-N divide-ratio sequencer for the ADPLL feedback divider.
// Selectable MASH order (0..3), frame-aligned retuning, minimum-N configuration check.
module adpll_frac_seq #(
    parameter int N_W = 11,
    parameter int F_W = 8
) (
    input  logic           i_ref_clk,
    input  logic           i_reset,
    input  logic [N_W-1:0] i_n_integer,
    input  logic [F_W-1:0] i_f_fraction,
    input  logic [1:0]     i_mode,
    input  logic           i_cfg_valid,
    output logic           o_cfg_ready,
    output logic           o_cfg_err,
    output logic [N_W:0]   o_div_ratio,
    output logic           o_div_valid,
    output logic           o_frame_start,
    output logic [1:0]     o_dbg_state
);

    // Handshake: a configuration transfers on any rising edge where
    // i_cfg_valid and o_cfg_ready are both high; o_cfg_ready depends only on state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam logic [F_W-1:0] FCNT_LAST = '1;

    state_t          r_state;
    state_t          w_next;
    logic [N_W-1:0]  r_n, r_sh_n;
    logic [F_W-1:0]  r_f, r_sh_f;
    logic [1:0]      r_mode, r_sh_mode;
    logic [F_W-1:0]  r_acc1, r_acc2, r_acc3, r_fcnt;
    logic            r_c2_d1, r_c3_d1, r_c3_d2;
    logic            r_cfg_err;
    logic [N_W:0]    r_div_ratio;
    logic            r_div_valid, r_frame_start;

    logic            w_ready, w_accept, w_cfg_ok;
    logic            w_load_cfg, w_load_shadow, w_capture, w_running;
    logic [N_W-1:0]  w_min_n;
    logic [F_W:0]    w_s1, w_s2, w_s3;
    logic            w_c1, w_c2, w_c3;
    logic signed [3:0] w_e1, w_e2, w_e3, w_y;
    logic [N_W:0]    w_ratio;

    always_comb begin
        w_min_n = N_W'(1);
        case (i_mode)
            2'd2:    w_min_n = N_W'(2);
            2'd3:    w_min_n = N_W'(4);
            default: w_min_n = N_W'(1);
        endcase
    end

    assign w_ready   = (r_state != S_PEND);
    assign w_accept  = i_cfg_valid && w_ready;
    assign w_cfg_ok  = (i_n_integer >= w_min_n);
    assign w_running = (r_state != S_IDLE);

    always_ff @(posedge i_ref_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_load_cfg    = 1'b0;
        w_load_shadow = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_cfg_ok) begin
                    w_load_cfg = 1'b1;
                    w_next     = S_RUN;
                end
            end
            S_RUN: begin
                // An accept in the last frame cycle is already at a boundary.
                if (w_accept && w_cfg_ok) begin
                    if (r_fcnt == FCNT_LAST) begin
                        w_load_cfg = 1'b1;
                    end else begin
                        w_capture = 1'b1;
                        w_next    = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (r_fcnt == FCNT_LAST) begin
                    w_load_shadow = 1'b1;
                    w_next        = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_s1 = {1'b0, r_acc1} + {1'b0, r_f};
    assign w_s2 = {1'b0, r_acc2} + {1'b0, w_s1[F_W-1:0]};
    assign w_s3 = {1'b0, r_acc3} + {1'b0, w_s2[F_W-1:0]};
    assign w_c1 = w_s1[F_W];
    assign w_c2 = w_s2[F_W];
    assign w_c3 = w_s3[F_W];

    assign w_e1 = $signed({3'b000, w_c1});
    assign w_e2 = $signed({3'b000, w_c2}) - $signed({3'b000, r_c2_d1});
    assign w_e3 = $signed({3'b000, w_c3}) - $signed({2'b00, r_c3_d1, 1'b0})
                + $signed({3'b000, r_c3_d2});

    always_comb begin
        w_y = 4'sd0;
        case (r_mode)
            2'd1:    w_y = w_e1;
            2'd2:    w_y = w_e1 + w_e2;
            2'd3:    w_y = w_e1 + w_e2 + w_e3;
            default: w_y = 4'sd0;
        endcase
    end

    // y is at least -3 and N is at least the mode minimum, so this never wraps.
    assign w_ratio = {1'b0, r_n} + {{(N_W-3){w_y[3]}}, w_y};

    always_ff @(posedge i_ref_clk) begin
        if (i_reset) begin
            r_n           <= '0;
            r_f           <= '0;
            r_mode        <= '0;
            r_sh_n        <= '0;
            r_sh_f        <= '0;
            r_sh_mode     <= '0;
            r_acc1        <= '0;
            r_acc2        <= '0;
            r_acc3        <= '0;
            r_fcnt        <= '0;
            r_c2_d1       <= 1'b0;
            r_c3_d1       <= 1'b0;
            r_c3_d2       <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_div_ratio   <= '0;
            r_div_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_cfg_err <= w_accept && !w_cfg_ok;
            if (w_running) begin
                r_div_ratio   <= w_ratio;
                r_div_valid   <= 1'b1;
                r_frame_start <= (r_fcnt == '0);
            end
            if (w_capture) begin
                r_sh_n    <= i_n_integer;
                r_sh_f    <= i_f_fraction;
                r_sh_mode <= i_mode;
            end
            if (w_load_cfg || w_load_shadow) begin
                r_n     <= w_load_shadow ? r_sh_n    : i_n_integer;
                r_f     <= w_load_shadow ? r_sh_f    : i_f_fraction;
                r_mode  <= w_load_shadow ? r_sh_mode : i_mode;
                r_acc1  <= '0;
                r_acc2  <= '0;
                r_acc3  <= '0;
                r_fcnt  <= '0;
                r_c2_d1 <= 1'b0;
                r_c3_d1 <= 1'b0;
                r_c3_d2 <= 1'b0;
            end else if (w_running) begin
                r_acc1  <= w_s1[F_W-1:0];
                r_acc2  <= w_s2[F_W-1:0];
                r_acc3  <= w_s3[F_W-1:0];
                r_fcnt  <= r_fcnt + 1'b1;
                r_c2_d1 <= w_c2;
                r_c3_d1 <= w_c3;
                r_c3_d2 <= r_c3_d1;
            end
        end
    end

    assign o_cfg_ready   = w_ready;
    assign o_cfg_err     = r_cfg_err;
    assign o_div_ratio   = r_div_ratio;
    assign o_div_valid   = r_div_valid;
    assign o_frame_start = r_frame_start;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_adpll_frac_seq.sv
// Directed bench for adpll_frac_seq: sequences, frame sums, retune timing,
// configuration rejection and reset priority.
module tb_adpll_frac_seq;

    localparam int N_W = 11;
    localparam int F_W = 8;

    logic           clk = 1'b0;
    logic           i_reset;
    logic [N_W-1:0] i_n_integer;
    logic [F_W-1:0] i_f_fraction;
    logic [1:0]     i_mode;
    logic           i_cfg_valid;
    logic           o_cfg_ready, o_cfg_err;
    logic [N_W:0]   o_div_ratio;
    logic           o_div_valid, o_frame_start;
    logic [1:0]     o_dbg_state;

    int n_total = 0;
    int n_bad = 0;
    logic last_ready;
    logic [N_W:0] exp_q[$];

    always #5 clk = ~clk;

    adpll_frac_seq #(.N_W(N_W), .F_W(F_W)) dut (
        .i_ref_clk    (clk),
        .i_reset      (i_reset),
        .i_n_integer  (i_n_integer),
        .i_f_fraction (i_f_fraction),
        .i_mode       (i_mode),
        .i_cfg_valid  (i_cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .o_cfg_err    (o_cfg_err),
        .o_div_ratio  (o_div_ratio),
        .o_div_valid  (o_div_valid),
        .o_frame_start(o_frame_start),
        .o_dbg_state  (o_dbg_state)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_cfg_valid = 1'b0;
        step();
        step();
        i_reset = 1'b0;
    endtask

    task automatic offer(input int n, input int f, input int m);
        i_n_integer  = N_W'(n);
        i_f_fraction = F_W'(f);
        i_mode       = 2'(m);
        i_cfg_valid  = 1'b1;
        last_ready   = o_cfg_ready;
        step();
        i_cfg_valid  = 1'b0;
    endtask

    initial begin
        int sum, fsum, total, extra_fs, mn, mx, bad_frames, ready_bad, const_bad, out_bad;
        i_reset = 1'b1;
        i_cfg_valid = 1'b0;
        i_n_integer = '0;
        i_f_fraction = '0;
        i_mode = '0;

        // Reset values
        do_reset();
        check_eq("rst_ready", o_cfg_ready, 1);
        check_eq("rst_err", o_cfg_err, 0);
        check_eq("rst_ratio", o_div_ratio, 0);
        check_eq("rst_valid", o_div_valid, 0);
        check_eq("rst_fs", o_frame_start, 0);
        check_eq("rst_state", o_dbg_state, 0);

        // MODE 1, N=31 F=159: hand-computed first samples and exact frame sum
        exp_q = '{12'd31, 12'd32, 12'd31, 12'd32, 12'd32, 12'd31, 12'd32, 12'd31};
        offer(31, 159, 1);
        check_eq("t1_ready_at_accept", last_ready, 1);
        check_eq("t1_no_sample_yet", o_div_valid, 0);
        check_eq("t1_state_run", o_dbg_state, 1);
        sum = 0;
        extra_fs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (i < 8) check_eq("t1_seq", o_div_ratio, int'(exp_q.pop_front()));
            if (i == 0) begin
                check_eq("t1_first_fs", o_frame_start, 1);
                check_eq("t1_first_valid", o_div_valid, 1);
            end else if (o_frame_start) begin
                extra_fs++;
            end
            sum += int'(o_div_ratio);
        end
        check_eq("t1_frame_sum", sum, 8095);
        check_eq("t1_extra_fs", extra_fs, 0);
        step();
        check_eq("t1_fs_period", o_frame_start, 1);

        // MODE 3 over 8 frames: bounded ratios and frame sums
        do_reset();
        offer(31, 159, 3);
        mn = 9999;
        mx = 0;
        bad_frames = 0;
        total = 0;
        extra_fs = 0;
        for (int fr = 0; fr < 8; fr++) begin
            fsum = 0;
            for (int i = 0; i < 256; i++) begin
                step();
                if (int'(o_div_ratio) < mn) mn = int'(o_div_ratio);
                if (int'(o_div_ratio) > mx) mx = int'(o_div_ratio);
                if ((i == 0) != o_frame_start) extra_fs++;
                fsum += int'(o_div_ratio);
            end
            if (fsum < 8092 || fsum > 8098) bad_frames++;
            total += fsum;
        end
        check_eq("t2_min_ge_28", int'(mn >= 28), 1);
        check_eq("t2_max_le_35", int'(mx <= 35), 1);
        check_eq("t2_bad_frames", bad_frames, 0);
        check_eq("t2_total_in_range", int'(total >= 64757 && total <= 64763), 1);
        check_eq("t2_fs_pattern", extra_fs, 0);

        // Mid-frame retune to N=40 F=0 MODE 2; second offer in PEND refused
        do_reset();
        offer(31, 159, 1);
        sum = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            sum += int'(o_div_ratio);
        end
        offer(40, 0, 2);
        sum += int'(o_div_ratio);
        check_eq("t3_accept_ready", last_ready, 1);
        check_eq("t3_pend_ready", o_cfg_ready, 0);
        check_eq("t3_pend_state", o_dbg_state, 2);
        offer(50, 0, 0);
        sum += int'(o_div_ratio);
        check_eq("t3_second_not_ready", last_ready, 0);
        ready_bad = 0;
        extra_fs = 0;
        for (int i = 102; i < 256; i++) begin
            step();
            sum += int'(o_div_ratio);
            if (i < 255 && o_cfg_ready) ready_bad++;
            if (o_frame_start) extra_fs++;
        end
        check_eq("t3_old_frame_sum", sum, 8095);
        check_eq("t3_ready_low_in_pend", ready_bad, 0);
        check_eq("t3_no_early_fs", extra_fs, 0);
        check_eq("t3_ready_after_boundary", o_cfg_ready, 1);
        check_eq("t3_state_after_boundary", o_dbg_state, 1);
        step();
        check_eq("t3_new_ratio", o_div_ratio, 40);
        check_eq("t3_new_fs", o_frame_start, 1);
        const_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_div_ratio != 12'd40) const_bad++;
        end
        check_eq("t3_const_40", const_bad, 0);

        // Rejected configuration, then minimum N for MODE 3
        do_reset();
        offer(3, 0, 3);
        check_eq("t4_err_pulse", o_cfg_err, 1);
        check_eq("t4_err_state_idle", o_dbg_state, 0);
        check_eq("t4_err_ready", o_cfg_ready, 1);
        check_eq("t4_err_no_valid", o_div_valid, 0);
        step();
        check_eq("t4_err_one_cycle", o_cfg_err, 0);
        offer(4, 159, 3);
        check_eq("t4_accept_state", o_dbg_state, 1);
        check_eq("t4_accept_no_err", o_cfg_err, 0);
        out_bad = 0;
        bad_frames = 0;
        for (int fr = 0; fr < 2; fr++) begin
            fsum = 0;
            for (int i = 0; i < 256; i++) begin
                step();
                if (o_div_ratio < 12'd1 || o_div_ratio > 12'd8) out_bad++;
                fsum += int'(o_div_ratio);
            end
            if (fsum < 1180 || fsum > 1186) bad_frames++;
        end
        check_eq("t4_range_1_8", out_bad, 0);
        check_eq("t4_frame_sums", bad_frames, 0);
        offer(1, 0, 2);
        check_eq("t4_run_err_mode2", o_cfg_err, 1);
        check_eq("t4_run_err_state", o_dbg_state, 1);
        check_eq("t4_run_err_ready", o_cfg_ready, 1);
        offer(0, 5, 0);
        check_eq("t4_run_err_mode0", o_cfg_err, 1);

        // Accept in the last frame cycle: applied at the very next frame start
        do_reset();
        offer(31, 159, 1);
        sum = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            sum += int'(o_div_ratio);
        end
        offer(40, 0, 0);
        sum += int'(o_div_ratio);
        check_eq("t5_last_old_fs", o_frame_start, 0);
        check_eq("t5_no_pend_state", o_dbg_state, 1);
        check_eq("t5_ready", o_cfg_ready, 1);
        check_eq("t5_old_frame_sum", sum, 8095);
        step();
        check_eq("t5_new_ratio", o_div_ratio, 40);
        check_eq("t5_new_fs", o_frame_start, 1);

        // Reset mid-frame concurrent with a configuration offer
        for (int i = 0; i < 37; i++) step();
        i_reset = 1'b1;
        i_n_integer = N_W'(50);
        i_f_fraction = '0;
        i_mode = 2'd0;
        i_cfg_valid = 1'b1;
        step();
        check_eq("t6_ratio", o_div_ratio, 0);
        check_eq("t6_valid", o_div_valid, 0);
        check_eq("t6_fs", o_frame_start, 0);
        check_eq("t6_err", o_cfg_err, 0);
        check_eq("t6_ready", o_cfg_ready, 1);
        check_eq("t6_state", o_dbg_state, 0);
        i_reset = 1'b0;
        i_cfg_valid = 1'b0;
        step();
        step();
        check_eq("t6_cfg_ignored_state", o_dbg_state, 0);
        check_eq("t6_cfg_ignored_valid", o_div_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adpll_frac_seq.md
# adpll_frac_seq

Parametrised fractional-N divide-ratio sequencer for the ADPLL feedback path, clocked by the reference clock. It accepts an integer/fraction frequency word through a valid/ready handshake. It produces one registered divide ratio per REF_CLK cycle using a selectable-order MASH (integer-only, MASH-1, MASH-1-1, MASH-1-1-1). It generalises the fixed N_INTEGER/F_FRACTION setting with parametrised widths, runtime order selection, frame-aligned retuning and configuration checking.

## Interface
- N_W, 11, width of N_INTEGER
- F_W, 8, width of F_FRACTION; frame length is 2^F_W cycles
- REF_CLK  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-high reset
- N_INTEGER  in  N_W  integer part of the divide ratio
- F_FRACTION  in  F_W  fractional part (value F/2^F_W)
- MODE  in  2  0 = integer only, 1/2/3 = MASH order
- CFG_VALID  in  1  configuration offered
- CFG_READY  out  1  configuration can be accepted
- CFG_ERR  out  1  one-cycle pulse: offered configuration rejected
- DIV_RATIO  out  N_W+1  divide ratio for the current reference cycle (unsigned)
- DIV_VALID  out  1  DIV_RATIO meaningful
- FRAME_START  out  1  marks the DIV_RATIO sample that starts a frame

## Operation
- States: IDLE (after reset), RUN, PEND. A configuration is accepted when CFG_VALID & CFG_READY.
- CFG_READY = 1 in IDLE and RUN, 0 in PEND.
- Check on accept: minimum N is 1, 1, 2, 4 for MODE 0..3. If N_INTEGER is below the minimum, pulse CFG_ERR next cycle, hold state and registers, and keep CFG_READY = 1.
- IDLE accept: at the next edge, latch N, F and MODE; clear all accumulators, carry delay lines and the frame counter fcnt; go to RUN.
- RUN accept: capture into the shadow registers and go to PEND. Exception: accept while fcnt = 2^F_W-1 applies immediately, like the boundary load below.
- PEND at fcnt = 2^F_W-1: at the next edge, load the shadow, clear the accumulators, delay lines and fcnt, and return to RUN. The output stream stays continuous.
- Datapath per RUN/PEND cycle, all arithmetic mod 2^F_W:
  - acc1 += F, carry c1
  - acc2 += new acc1, carry c2
  - acc3 += new acc2, carry c3
- Offset y by mode:
  - MODE 0: y = 0
  - MODE 1: y = c1
  - MODE 2: y = c1 + c2 − c2[-1]
  - MODE 3: y = c1 + c2 − c2[-1] + c3 − 2·c3[-1] + c3[-2]
- Computation width: signed, at least F_W-independent 4 bits. Range of y is 0..1, −1..2, −3..4 for MODE 1..3.
- DIV_RATIO <= N + y, registered. It never underflows because of the minimum-N check. N_W+1 bits always hold N+4.
- F = 0: DIV_RATIO = N constantly, in every mode.
- fcnt increments every RUN/PEND cycle and wraps at 2^F_W. FRAME_START accompanies the sample computed at fcnt = 0.

## Timing
- Reset values: state IDLE, CFG_READY=1, CFG_ERR=0, DIV_RATIO=0, DIV_VALID=0, FRAME_START=0, and all accumulators, delay lines, shadow registers and fcnt = 0.
- RESET has priority over everything, including a concurrent CFG_VALID. Reset mid-frame returns to IDLE in one edge.
- Latency: accept at edge t → RUN from t+1 → first DIV_VALID=1 with FRAME_START=1 at t+2.
- DIV_VALID stays 1 until reset.
- Retune: the first new-config sample appears 2 cycles after the boundary-cycle edge, with FRAME_START=1. No gap and no duplicate sample.
- CFG_ERR is independent of state and never blocks a later valid offer.

## Test plan
- N=31, F=159, MODE 1, F_W=8 from IDLE → outputs 31,32,31,32,… starting 2 cycles after accept with FRAME_START on the first sample. The sum over each 256-sample frame is exactly 8095. FRAME_START repeats every 256 cycles.
- Same word with MODE 3 for 8 frames → every DIV_RATIO is in 28..35. Each frame sum is within 8095±3. The 8-frame sum is within 64760±3.
- Accept N=40, F=0, MODE 2 mid-frame while running N=31/F=159 → CFG_READY=0 until the boundary, old ratios continue to the frame end, then the constant 40 starts with FRAME_START. A second offer during PEND is not accepted.
- Offer N=3, MODE 3 → one-cycle CFG_ERR, no state change. A following N=4, MODE 3 offer is accepted, and the outputs stay within 1..8.
- Accept exactly at fcnt=255 → the new config appears at the very next frame start, with no extra frame of delay.
- Assert RESET mid-frame concurrent with CFG_VALID → all outputs at reset values next cycle, config ignored, IDLE with CFG_READY=1.
